// File: rtl/acc_pkg.sv
// Shared accelerator row geometry, pointer-width helper and unloader state type.
package acc_pkg;

  // Default row geometry, common to the serial-to-parallel collector and the unloader
  localparam int unsigned DEF_DW = 32;
  localparam int unsigned DEF_DP = 56;

  // Index width for an n-entry row; never narrower than one bit
  function automatic int unsigned PTR_W(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/par2ser.sv
// Parallel-to-serial row unloader: takes one DP-element packed row and
// streams it out element 0 first, one DW-bit element per accepted beat.
module par2ser
  import acc_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned DP = DEF_DP
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW*DP-1:0]       data_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DW-1:0]          data_o,
  output logic [PTR_W(DP)-1:0]   out_idx,
  output logic                   out_last,
  output logic                   busy
);

  localparam int unsigned   PW       = PTR_W(DP);
  localparam logic [PW-1:0] LAST_IDX = PW'(DP - 1);

  state_t                   state;
  state_t                   state_nxt;
  logic [PW-1:0]            rd_ptr;
  logic [PW-1:0]            rd_ptr_nxt;
  logic [DP-1:0][DW-1:0]    row_q;
  logic                     at_last;
  logic                     beat;
  logic                     load;

  // Next-state, pointer update and handshake decode; abort beats load beats a beat
  always_comb begin
    state_nxt  = state;
    rd_ptr_nxt = rd_ptr;
    out_valid  = (state == SHIFT);
    busy       = (state == SHIFT);
    at_last    = out_valid && (rd_ptr == LAST_IDX);
    beat       = out_valid && out_ready;
    in_ready   = !clr && ((state == IDLE) || (at_last && out_ready));
    load       = in_valid && in_ready;

    if (clr) begin
      state_nxt  = IDLE;
      rd_ptr_nxt = '0;
    end else if (load) begin
      state_nxt  = SHIFT;
      rd_ptr_nxt = '0;
    end else if (beat) begin
      if (at_last) begin
        state_nxt  = IDLE;
        rd_ptr_nxt = '0;
      end else begin
        rd_ptr_nxt = rd_ptr + PW'(1);
      end
    end
  end

  // State, read pointer and row buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rd_ptr <= '0;
      row_q  <= '0;
    end else begin
      state  <= state_nxt;
      rd_ptr <= rd_ptr_nxt;
      if (load) begin
        row_q <= data_i;
      end
    end
  end

  // Element select from the held row; zero when nothing is presented
  always_comb begin
    data_o   = out_valid ? row_q[rd_ptr] : '0;
    out_idx  = rd_ptr;
    out_last = at_last;
  end

endmodule
